sram_rr_ctrl: RTL and testbench

Shared-access controller for a single-port 64x32 SRAM macro. It arbitrates NUM_PORTS requesters onto the macro with round-robin fairness and fixed one-cycle read latency, and drives the macro's chip-select, write-enable and output-enable pins. After reset it optionally runs an initialisation pass that zero-fills the array. It sits directly in front of the macro; the macro's CE pin is tied to the same clk.

---
 rtl/sram_ctrl_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 59 +++++
 rtl/sram_rr_ctrl.sv | 126 ++++++++++++
 tb/tb_sram_rr_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared types and default widths for the round-robin SRAM controller.
//   state_e : controller phase (zero-fill walk, normal arbitration)
//   req_t   : one requester's payload at the default macro geometry
package sram_ctrl_pkg;

    localparam int unsigned ADDR_W_DEF = 6;
    localparam int unsigned DATA_W_DEF = 32;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    typedef struct packed {
        logic                  we;
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] wdata;
    } req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant over NUM_PORTS requesters.
//   clk, rst   : clock, synchronous active-high reset (pointer -> port 0)
//   req_i      : per-port request
//   accept_i   : a grant was taken this cycle; advance the pointer past it
//   gnt_o      : one-hot (or zero) combinational grant
module rr_arbiter #(
    parameter int unsigned NUM_PORTS = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic                 accept_i,
    output logic [NUM_PORTS-1:0] gnt_o
);

    localparam int unsigned PTR_W = $clog2(NUM_PORTS);

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;
    logic [PTR_W-1:0] gnt_idx;
    logic             found;
    int unsigned      idx;

    // Scan from the pointer, wrapping, and take the first requester
    always_comb begin
        gnt_o   = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            idx = 32'(ptr_q) + k;
            if (idx >= NUM_PORTS) begin
                idx = idx - NUM_PORTS;
            end
            if (!found && req_i[PTR_W'(idx)]) begin
                gnt_o[PTR_W'(idx)] = 1'b1;
                gnt_idx            = PTR_W'(idx);
                found              = 1'b1;
            end
        end
    end

    // Highest priority moves to the port after the one just served
    always_comb begin
        ptr_d = ptr_q;
        if (accept_i) begin
            ptr_d = (gnt_idx == PTR_W'(NUM_PORTS - 1)) ? '0 : gnt_idx + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/sram_rr_ctrl.sv
// Shared-access controller for a single-port SRAM macro.
//   clk, rst              : clock (also the macro CE), synchronous active-high reset
//   req_valid/ready/we/addr/wdata : per-port request channel, round-robin granted
//   resp_valid, resp_rdata: one-cycle-latency read response (shared data bus)
//   init_done             : array usable (zero-fill finished or not required)
//   sram_a/csb/web/oeb/i  : macro pins, sram_o: macro read data
module sram_rr_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned NUM_PORTS = 2,
    parameter int unsigned ADDR_W    = ADDR_W_DEF,
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter bit          INIT_ZERO = 1'b1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_PORTS-1:0]             req_valid,
    output logic [NUM_PORTS-1:0]             req_ready,
    input  logic [NUM_PORTS-1:0]             req_we,
    input  logic [NUM_PORTS-1:0][ADDR_W-1:0] req_addr,
    input  logic [NUM_PORTS-1:0][DATA_W-1:0] req_wdata,
    output logic [NUM_PORTS-1:0]             resp_valid,
    output logic [DATA_W-1:0]                resp_rdata,
    output logic                             init_done,
    output logic [ADDR_W-1:0]                sram_a,
    output logic                             sram_csb,
    output logic                             sram_web,
    output logic                             sram_oeb,
    output logic [DATA_W-1:0]                sram_i,
    input  logic [DATA_W-1:0]                sram_o
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } sel_req_t;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [NUM_PORTS-1:0] pend_q, pend_d;
    logic [NUM_PORTS-1:0] gnt;
    logic                 init_active;
    logic                 run_en;
    sel_req_t             sel;

    // Reset overrides every pin immediately, not just at the next edge
    assign init_active = (state_q == ST_INIT) && !rst;
    assign run_en      = (state_q == ST_RUN) && !rst;

    rr_arbiter #(
        .NUM_PORTS (NUM_PORTS)
    ) u_arb (
        .clk      (clk),
        .rst      (rst),
        .req_i    (req_valid & {NUM_PORTS{run_en}}),
        .accept_i (|gnt),
        .gnt_o    (gnt)
    );

    assign req_ready = gnt;

    // Payload of the granted port (zero when nothing is granted)
    always_comb begin
        sel = '0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            if (gnt[p]) begin
                sel.we    = req_we[p];
                sel.addr  = req_addr[p];
                sel.wdata = req_wdata[p];
            end
        end
    end

    // Zero-fill walk and read-pending capture
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = gnt & ~req_we;
        if (state_q == ST_INIT) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(DEPTH - 1)) begin
                state_d = ST_RUN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= INIT_ZERO ? ST_INIT : ST_RUN;
            cnt_q   <= '0;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
        end
    end

    // Macro pin mux: init write, granted access, or idle
    always_comb begin
        sram_csb = 1'b1;
        sram_web = 1'b1;
        sram_a   = '0;
        sram_i   = '0;
        if (init_active) begin
            sram_csb = 1'b0;
            sram_web = 1'b0;
            sram_a   = cnt_q[ADDR_W-1:0];
        end else if (|gnt) begin
            sram_csb = 1'b0;
            sram_web = ~sel.we;
            sram_a   = sel.addr;
            sram_i   = sel.wdata;
        end
    end

    assign resp_valid = pend_q & {NUM_PORTS{~rst}};
    assign sram_oeb   = ~(|resp_valid);
    assign resp_rdata = (|resp_valid) ? sram_o : '0;
    assign init_done  = (state_q == ST_RUN);

endmodule

// File: tb/tb_sram_rr_ctrl.sv
// Bench for sram_rr_ctrl: behavioural macro + reference model, per-cycle compare,
// and directed scenarios with hand-computed literals.
module tb_sram_rr_ctrl;

    localparam int NP    = 2;
    localparam int AW    = 6;
    localparam int DW    = 32;
    localparam int DEPTH = 64;

    logic                     clk;
    logic                     rst;
    logic [NP-1:0]            req_valid;
    logic [NP-1:0]            req_ready;
    logic [NP-1:0]            req_we;
    logic [NP-1:0][AW-1:0]    req_addr;
    logic [NP-1:0][DW-1:0]    req_wdata;
    logic [NP-1:0]            resp_valid;
    logic [DW-1:0]            resp_rdata;
    logic                     init_done;
    logic [AW-1:0]            sram_a;
    logic                     sram_csb;
    logic                     sram_web;
    logic                     sram_oeb;
    logic [DW-1:0]            sram_i;
    logic [DW-1:0]            sram_o;

    int n_vec = 0;
    int n_mis = 0;
    bit chk_en = 0;

    sram_rr_ctrl #(
        .NUM_PORTS (NP),
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .INIT_ZERO (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .init_done  (init_done),
        .sram_a     (sram_a),
        .sram_csb   (sram_csb),
        .sram_web   (sram_web),
        .sram_oeb   (sram_oeb),
        .sram_i     (sram_i),
        .sram_o     (sram_o)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // Behavioural single-port macro with registered read data
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (!sram_csb) begin
            if (!sram_web) mem[sram_a] <= sram_i;
            else           sram_o      <= mem[sram_a];
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: what the controller must do, in plain terms
    bit          m_init;
    int          m_cnt;
    int          m_ptr;
    int          m_pend;
    logic [DW-1:0] m_pdata;
    logic [DW-1:0] ref_mem [DEPTH];

    function automatic int model_grant();
        int p;
        if (rst || m_init) return -1;
        for (int k = 0; k < NP; k++) begin
            p = (m_ptr + k) % NP;
            if (req_valid[p]) return p;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        int g;
        g = model_grant();
        if (rst) begin
            m_init = 1;
            m_cnt  = 0;
            m_ptr  = 0;
            m_pend = -1;
        end else begin
            m_pend = -1;
            if (m_init) begin
                ref_mem[m_cnt] = '0;
                m_cnt++;
                if (m_cnt == DEPTH) m_init = 0;
            end else if (g >= 0) begin
                m_ptr = (g + 1) % NP;
                if (req_we[g]) begin
                    ref_mem[req_addr[g]] = req_wdata[g];
                end else begin
                    m_pend  = g;
                    m_pdata = ref_mem[req_addr[g]];
                end
            end
        end
        chk_en = 1;
    end

    // Per-cycle compare of every output against the model
    always @(negedge clk) begin
        int            g;
        logic [NP-1:0] e_rdy;
        logic [NP-1:0] e_rv;
        if (chk_en) begin
            g     = model_grant();
            e_rdy = '0;
            if (g >= 0) e_rdy[g] = 1'b1;
            e_rv = '0;
            if (!rst && m_pend >= 0) e_rv[m_pend] = 1'b1;
            chk("req_ready", 64'(req_ready), 64'(e_rdy));
            chk("resp_valid", 64'(resp_valid), 64'(e_rv));
            chk("sram_oeb", 64'(sram_oeb), 64'(e_rv == '0));
            chk("resp_rdata", 64'(resp_rdata), (e_rv != '0) ? 64'(m_pdata) : 64'd0);
            chk("init_done", 64'(init_done), 64'(!m_init));
            if (rst) begin
                chk("rst_csb", 64'(sram_csb), 64'd1);
                chk("rst_web", 64'(sram_web), 64'd1);
            end else if (m_init) begin
                chk("init_csb", 64'(sram_csb), 64'd0);
                chk("init_web", 64'(sram_web), 64'd0);
                chk("init_a", 64'(sram_a), 64'(m_cnt));
                chk("init_i", 64'(sram_i), 64'd0);
            end else if (g >= 0) begin
                chk("acc_csb", 64'(sram_csb), 64'd0);
                chk("acc_web", 64'(sram_web), 64'(!req_we[g]));
                chk("acc_a", 64'(sram_a), 64'(req_addr[g]));
                chk("acc_i", 64'(sram_i), 64'(req_wdata[g]));
            end else begin
                chk("idle_csb", 64'(sram_csb), 64'd1);
                chk("idle_a", 64'(sram_a), 64'd0);
                chk("idle_i", 64'(sram_i), 64'd0);
            end
        end
    end

    // Response tallies for directed checks
    int            resp_cnt [NP];
    logic [DW-1:0] resp_or;
    initial begin
        resp_cnt = '{default: 0};
        resp_or  = '0;
        forever begin
            @(negedge clk);
            for (int p = 0; p < NP; p++) begin
                if (resp_valid[p]) begin
                    resp_cnt[p]++;
                    resp_or = resp_or | resp_rdata;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_init(output int n);
        n = 0;
        while (!init_done && n < 200) begin
            step();
            n++;
        end
    endtask

    // Present one request and hold it until the handshake edge has passed
    task automatic access(input int p, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int n;
        req_valid[p] = 1'b1;
        req_we[p]    = we;
        req_addr[p]  = a;
        req_wdata[p] = d;
        #1;
        n = 0;
        while (!req_ready[p] && n < 50) begin
            step();
            #1;
            n++;
        end
        chk("access_timeout", 64'(n >= 50), 64'd0);
        step();
        req_valid[p] = 1'b0;
    endtask

    initial begin
        int n;
        int c0, c1;
        int gseq [6];

        rst       = 1;
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;

        // Reset, zero-fill, then read the whole array from port 0
        step();
        step();
        chk("reset_done_low", 64'(init_done), 64'd0);
        chk("reset_ready", 64'(req_ready), 64'd0);
        rst = 0;
        #1;
        chk("init_first_addr", 64'(sram_a), 64'd0);
        chk("init_first_csb", 64'(sram_csb), 64'd0);
        wait_init(n);
        chk("init_latency", 64'(n), 64'd64);
        c0 = resp_cnt[0];
        resp_or = '0;
        for (int a = 0; a < DEPTH; a++) access(0, 1'b0, AW'(a), '0);
        step();
        chk("zero_fill_count", 64'(resp_cnt[0] - c0), 64'd64);
        chk("zero_fill_data", 64'(resp_or), 64'd0);

        // Write then read back next cycle
        access(0, 1'b1, 6'd5, 32'hDEADBEEF);
        access(0, 1'b0, 6'd5, '0);
        #1;
        chk("raw_valid", 64'(resp_valid), 64'd1);
        chk("raw_data", 64'(resp_rdata), 64'hDEADBEEF);

        // Port 1 writes, port 0 reads the same address the following cycle
        access(1, 1'b1, 6'd63, 32'h12345678);
        access(0, 1'b0, 6'd63, '0);
        #1;
        chk("xport_valid", 64'(resp_valid), 64'd1);
        chk("xport_data", 64'(resp_rdata), 64'h12345678);

        // Serve port 1 once so port 0 leads, then contend for 6 cycles
        access(1, 1'b0, 6'd0, '0);
        c0 = resp_cnt[0];
        c1 = resp_cnt[1];
        req_valid = 2'b11;
        req_we    = 2'b00;
        req_addr[0] = 6'd1;
        req_addr[1] = 6'd2;
        for (int i = 0; i < 6; i++) begin
            #1;
            gseq[i] = req_ready[1] ? 1 : (req_ready[0] ? 0 : -1);
            step();
        end
        req_valid = '0;
        step();
        for (int i = 0; i < 6; i++) chk("rr_order", 64'(gseq[i]), 64'(i % 2));
        chk("rr_resp_p0", 64'(resp_cnt[0] - c0), 64'd3);
        chk("rr_resp_p1", 64'(resp_cnt[1] - c1 - 1), 64'd3);

        // Reset in the middle of the zero-fill walk
        rst = 1;
        step();
        step();
        rst = 0;
        for (int i = 0; i < 30; i++) step();
        #1;
        chk("mid_init_addr", 64'(sram_a), 64'd30);
        rst = 1;
        step();
        rst = 0;
        #1;
        chk("restart_addr", 64'(sram_a), 64'd0);
        wait_init(n);
        chk("restart_latency", 64'(n), 64'd64);

        // Reset landing on a pending read response
        access(0, 1'b0, 6'd7, '0);
        rst = 1;
        #1;
        chk("drop_resp_valid", 64'(resp_valid), 64'd0);
        chk("drop_oeb", 64'(sram_oeb), 64'd1);
        step();
        step();
        rst = 0;
        wait_init(n);
        chk("post_drop_latency", 64'(n), 64'd64);
        req_valid = 2'b11;
        #1;
        chk("ptr_reset", 64'(req_ready), 64'd1);
        step();
        req_valid = '0;
        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
